// File: rtl/ibex_instr_bus_pkg.sv
// Shared types and helpers for the instruction-fetch bus responder.
package ibex_instr_bus_pkg;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } instr_resp_t;

  localparam int MaxExtraLatency = 7;

  // Word offset of a byte address relative to the mapped base.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/ibex_instr_resp_delay.sv
// Response delay line: stage 0 marks the SRAM data-return cycle, then ExtraLatency
// registered stages carry the completed response to the output.
module ibex_instr_resp_delay
  import ibex_instr_bus_pkg::*;
#(
  parameter int unsigned ExtraLatency = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_push,
  input  logic        i_push_err,
  input  logic [31:0] i_sram_rdata,
  output instr_resp_t o_tail
);

  logic        r_s0_valid;
  logic        r_s0_err;
  instr_resp_t w_stage0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0_valid <= 1'b0;
      r_s0_err   <= 1'b0;
    end else begin
      r_s0_valid <= i_push;
      r_s0_err   <= i_push & i_push_err;
    end
  end

  // SRAM data is only meaningful in the cycle after a granted in-range strobe.
  always_comb begin
    w_stage0       = '0;
    w_stage0.valid = r_s0_valid;
    w_stage0.err   = r_s0_err;
    if (r_s0_valid && !r_s0_err) begin
      w_stage0.rdata = i_sram_rdata;
    end
  end

  generate
    if (ExtraLatency == 0) begin : g_direct
      assign o_tail = w_stage0;
    end else begin : g_shift
      instr_resp_t r_shift [ExtraLatency];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          for (int unsigned i = 0; i < ExtraLatency; i++) begin
            r_shift[i] <= '0;
          end
        end else begin
          r_shift[0] <= w_stage0;
          for (int unsigned i = 1; i < ExtraLatency; i++) begin
            r_shift[i] <= r_shift[i-1];
          end
        end
      end

      assign o_tail = r_shift[ExtraLatency-1];
    end
  endgenerate

endmodule

// File: rtl/ibex_instr_bus_responder.sv
// Instruction-fetch bus responder: req/gnt/rvalid front end for a shared 1-cycle SRAM,
// with address range checking, an outstanding-credit limit and a fixed response delay.
module ibex_instr_bus_responder
  import ibex_instr_bus_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned MemWords       = 4096,
  parameter int unsigned ExtraLatency   = 0,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_req_i,
  input  logic [31:0]                 instr_addr_i,
  output logic                        instr_gnt_o,
  output logic                        instr_rvalid_o,
  output logic [31:0]                 instr_rdata_o,
  output logic                        instr_err_o,
  output logic                        sram_req_o,
  output logic [$clog2(MemWords)-1:0] sram_addr_o,
  input  logic                        sram_gnt_i,
  input  logic [31:0]                 sram_rdata_i,
  output logic [3:0]                  outstanding_o
);

  localparam int unsigned AddrW      = $clog2(MemWords);
  localparam logic [32:0] RangeBytes = 33'(MemWords) << 2;
  localparam logic [3:0]  MaxOut     = 4'(MaxOutstanding);

  generate
    if (ExtraLatency > MaxExtraLatency) begin : g_bad_latency
      $error("ExtraLatency out of range");
    end
    if (MaxOutstanding < 1 || MaxOutstanding > 8) begin : g_bad_outstanding
      $error("MaxOutstanding out of range");
    end
    if (MemWords < 2 || (MemWords & (MemWords - 1)) != 0) begin : g_bad_words
      $error("MemWords must be a power of two >= 2");
    end
    if (BaseAddr[1:0] != 2'b00) begin : g_bad_base
      $error("BaseAddr must be word aligned");
    end
  endgenerate

  logic [31:0] w_offset;
  logic        w_in_range;
  logic        w_out_of_range;
  logic        w_can_accept;
  logic        w_gnt;
  logic        w_fire;
  logic [3:0]  r_outstanding;
  instr_resp_t w_tail;

  // Addresses below the base wrap to large offsets and fail the range check.
  assign w_offset       = instr_addr_i - BaseAddr;
  assign w_in_range     = {1'b0, w_offset} < RangeBytes;
  assign w_out_of_range = ~w_in_range;

  // A response leaving this cycle frees its credit for a same-cycle grant.
  assign w_fire       = w_tail.valid;
  assign w_can_accept = (r_outstanding < MaxOut) | w_fire;
  assign w_gnt        = instr_req_i & w_can_accept & (sram_gnt_i | w_out_of_range);

  assign instr_gnt_o = w_gnt;
  assign sram_req_o  = instr_req_i & w_in_range & w_can_accept;
  assign sram_addr_o = AddrW'(word_index(instr_addr_i, BaseAddr));

  ibex_instr_resp_delay #(
    .ExtraLatency (ExtraLatency)
  ) u_delay (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_push       (w_gnt),
    .i_push_err   (w_out_of_range),
    .i_sram_rdata (sram_rdata_i),
    .o_tail       (w_tail)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outstanding <= 4'd0;
    end else if (w_gnt && !w_fire) begin
      r_outstanding <= r_outstanding + 4'd1;
    end else if (!w_gnt && w_fire) begin
      r_outstanding <= r_outstanding - 4'd1;
    end
  end

  assign instr_rvalid_o = w_tail.valid;
  assign instr_err_o    = w_tail.valid & w_tail.err;
  assign instr_rdata_o  = w_tail.valid ? w_tail.rdata : 32'h0;
  assign outstanding_o  = r_outstanding;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    r_outstanding <= MaxOut);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_fire && r_outstanding == 4'd0));

endmodule

// File: tb/tb_ibex_instr_bus_responder.sv
// Directed bench: four responder instances with different latency/credit settings,
// each fed by a small SRAM model that returns garbage unless a strobe was granted.
module tb_ibex_instr_bus_responder;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int unsigned WORDS = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        req    [4];
  logic [31:0] addr   [4];
  logic        gnt    [4];
  logic        rvalid [4];
  logic [31:0] rdata  [4];
  logic        err    [4];
  logic        sreq   [4];
  logic [3:0]  saddr  [4];
  logic        sgnt   [4];
  logic [31:0] srdata [4];
  logic [3:0]  outst  [4];

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem_word(input logic [3:0] idx);
    return 32'hC0DE_0000 | (32'(idx) * 32'h0000_0111);
  endfunction

  always @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      srdata[k] <= (sreq[k] && sgnt[k]) ? mem_word(saddr[k]) : 32'hDEAD_BEEF;
    end
  end

  ibex_instr_bus_responder #(.BaseAddr(BASE), .MemWords(WORDS), .ExtraLatency(0), .MaxOutstanding(2)) u0 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]), .sram_req_o(sreq[0]),
    .sram_addr_o(saddr[0]), .sram_gnt_i(sgnt[0]), .sram_rdata_i(srdata[0]), .outstanding_o(outst[0]));

  ibex_instr_bus_responder #(.BaseAddr(BASE), .MemWords(WORDS), .ExtraLatency(1), .MaxOutstanding(2)) u1 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]), .sram_req_o(sreq[1]),
    .sram_addr_o(saddr[1]), .sram_gnt_i(sgnt[1]), .sram_rdata_i(srdata[1]), .outstanding_o(outst[1]));

  ibex_instr_bus_responder #(.BaseAddr(BASE), .MemWords(WORDS), .ExtraLatency(2), .MaxOutstanding(1)) u2 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_req_i(req[2]), .instr_addr_i(addr[2]), .instr_gnt_o(gnt[2]),
    .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]), .instr_err_o(err[2]), .sram_req_o(sreq[2]),
    .sram_addr_o(saddr[2]), .sram_gnt_i(sgnt[2]), .sram_rdata_i(srdata[2]), .outstanding_o(outst[2]));

  ibex_instr_bus_responder #(.BaseAddr(BASE), .MemWords(WORDS), .ExtraLatency(3), .MaxOutstanding(2)) u3 (
    .clk_i(clk_i), .rst_i(rst_i), .instr_req_i(req[3]), .instr_addr_i(addr[3]), .instr_gnt_o(gnt[3]),
    .instr_rvalid_o(rvalid[3]), .instr_rdata_o(rdata[3]), .instr_err_o(err[3]), .sram_req_o(sreq[3]),
    .sram_addr_o(saddr[3]), .sram_gnt_i(sgnt[3]), .sram_rdata_i(srdata[3]), .outstanding_o(outst[3]));

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rvalid[k] !== 1'b0) begin errors++; $display("FAIL reset_rvalid[%0d]: got %b want 0", k, rvalid[k]); end
      checks++; if (err[k] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", k, err[k]); end
      checks++; if (rdata[k] !== 32'h0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata[k]); end
      checks++; if (outst[k] !== 4'd0) begin errors++; $display("FAIL reset_outstanding[%0d]: got %0d want 0", k, outst[k]); end
    end
    tick();
    rst_i = 1'b0;
    addr[0] = BASE + 32'd4;
    #2;
    checks++; if (gnt[0] !== 1'b0) begin errors++; $display("FAIL idle_gnt: got %b want 0", gnt[0]); end
    checks++; if (sreq[0] !== 1'b0) begin errors++; $display("FAIL idle_sram_req: got %b want 0", sreq[0]); end
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got %b want 0", rvalid[0]); end
  endtask

  task automatic test_single_fetch();
    tick();
    req[0] = 1'b1; addr[0] = BASE + 32'd8; sgnt[0] = 1'b1;
    #2;
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt[0]); end
    checks++; if (sreq[0] !== 1'b1) begin errors++; $display("FAIL single_sram_req: got %b want 1", sreq[0]); end
    checks++; if (saddr[0] !== 4'd2) begin errors++; $display("FAIL single_sram_addr: got %0d want 2", saddr[0]); end
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL single_early_rvalid: got %b want 0", rvalid[0]); end
    tick();
    req[0] = 1'b0; addr[0] = 32'h0;
    #2;
    checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b want 1", rvalid[0]); end
    checks++; if (rdata[0] !== mem_word(4'd2)) begin errors++; $display("FAIL single_rdata: got %h want %h", rdata[0], mem_word(4'd2)); end
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err[0]); end
    checks++; if (outst[0] !== 4'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outst[0]); end
    tick();
    #2;
    checks++; if (rvalid[0] !== 1'b0) begin errors++; $display("FAIL single_rvalid_pulse: got %b want 0", rvalid[0]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL single_rdata_idle: got %h want 0", rdata[0]); end
    checks++; if (outst[0] !== 4'd0) begin errors++; $display("FAIL single_outstanding_end: got %0d want 0", outst[0]); end
  endtask

  task automatic test_out_of_range();
    tick();
    req[0] = 1'b1; addr[0] = BASE + 32'(WORDS * 4); sgnt[0] = 1'b0;
    #2;
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL oor_high_gnt: got %b want 1", gnt[0]); end
    checks++; if (sreq[0] !== 1'b0) begin errors++; $display("FAIL oor_high_sram_req: got %b want 0", sreq[0]); end
    tick();
    addr[0] = BASE - 32'd4;
    #2;
    checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL oor_low_gnt: got %b want 1", gnt[0]); end
    checks++; if (sreq[0] !== 1'b0) begin errors++; $display("FAIL oor_low_sram_req: got %b want 0", sreq[0]); end
    checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL oor_high_rvalid: got %b want 1", rvalid[0]); end
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL oor_high_err: got %b want 1", err[0]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL oor_high_rdata: got %h want 0", rdata[0]); end
    tick();
    req[0] = 1'b0; addr[0] = 32'h0; sgnt[0] = 1'b1;
    #2;
    checks++; if (rvalid[0] !== 1'b1) begin errors++; $display("FAIL oor_low_rvalid: got %b want 1", rvalid[0]); end
    checks++; if (err[0] !== 1'b1) begin errors++; $display("FAIL oor_low_err: got %b want 1", err[0]); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL oor_low_rdata: got %h want 0", rdata[0]); end
    tick();
    #2;
    checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL oor_err_idle: got %b want 0", err[0]); end
    checks++; if (outst[0] !== 4'd0) begin errors++; $display("FAIL oor_outstanding_end: got %0d want 0", outst[0]); end
  endtask

  task automatic test_contention();
    for (int c = 0; c < 5; c++) begin
      tick();
      req[0]  = (c < 4);
      addr[0] = BASE + 32'(4 * (WORDS - 1));
      sgnt[0] = (c >= 3);
      #2;
      if (c < 3) begin
        checks++; if (gnt[0] !== 1'b0) begin errors++; $display("FAIL contend_gnt c%0d: got %b want 0", c, gnt[0]); end
        checks++; if (sreq[0] !== 1'b1) begin errors++; $display("FAIL contend_sram_req c%0d: got %b want 1", c, sreq[0]); end
      end
      if (c == 3) begin
        checks++; if (gnt[0] !== 1'b1) begin errors++; $display("FAIL contend_gnt_release: got %b want 1", gnt[0]); end
        checks++; if (saddr[0] !== 4'd15) begin errors++; $display("FAIL contend_sram_addr: got %0d want 15", saddr[0]); end
      end
      checks++; if (rvalid[0] !== (c == 4)) begin errors++; $display("FAIL contend_rvalid c%0d: got %b want %b", c, rvalid[0], (c == 4)); end
      if (c == 4) begin
        checks++; if (rdata[0] !== mem_word(4'd15)) begin errors++; $display("FAIL contend_rdata: got %h want %h", rdata[0], mem_word(4'd15)); end
        checks++; if (err[0] !== 1'b0) begin errors++; $display("FAIL contend_err: got %b want 0", err[0]); end
      end
    end
  endtask

  task automatic test_streaming();
    int g;
    int exp_out [8];
    g = 0;
    exp_out = '{0, 1, 2, 2, 2, 1, 0, 0};
    for (int c = 0; c < 8; c++) begin
      tick();
      req[1]  = (g < 4);
      addr[1] = BASE + 32'(4 * g);
      #2;
      if (c < 4) begin
        checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL stream_gnt c%0d: got %b want 1", c, gnt[1]); end
      end
      checks++; if (rvalid[1] !== (c >= 2 && c <= 5)) begin errors++; $display("FAIL stream_rvalid c%0d: got %b want %b", c, rvalid[1], (c >= 2 && c <= 5)); end
      if (c >= 2 && c <= 5) begin
        checks++; if (rdata[1] !== mem_word(4'(c - 2))) begin errors++; $display("FAIL stream_rdata c%0d: got %h want %h", c, rdata[1], mem_word(4'(c - 2))); end
      end
      checks++; if (outst[1] !== 4'(exp_out[c])) begin errors++; $display("FAIL stream_outstanding c%0d: got %0d want %0d", c, outst[1], exp_out[c]); end
      if (gnt[1] === 1'b1) g++;
    end
    req[1] = 1'b0;
  endtask

  task automatic test_credit_stall();
    int g;
    g = 0;
    for (int c = 0; c < 9; c++) begin
      tick();
      req[2]  = (g < 2);
      addr[2] = BASE + 32'(4 * g);
      #2;
      checks++; if (gnt[2] !== (c == 0 || c == 3)) begin errors++; $display("FAIL credit_gnt c%0d: got %b want %b", c, gnt[2], (c == 0 || c == 3)); end
      checks++; if (rvalid[2] !== (c == 3 || c == 6)) begin errors++; $display("FAIL credit_rvalid c%0d: got %b want %b", c, rvalid[2], (c == 3 || c == 6)); end
      if (c == 3 || c == 6) begin
        checks++; if (rdata[2] !== mem_word(4'(c / 3 - 1))) begin errors++; $display("FAIL credit_rdata c%0d: got %h want %h", c, rdata[2], mem_word(4'(c / 3 - 1))); end
      end
      if (gnt[2] === 1'b1) g++;
    end
    req[2] = 1'b0;
  endtask

  task automatic test_reset_midflight();
    int pulses;
    int seen;
    logic [31:0] got;
    pulses = 0;
    seen = -1;
    got = 32'h0;
    tick();
    req[3] = 1'b1; addr[3] = BASE; sgnt[3] = 1'b1;
    #2;
    checks++; if (gnt[3] !== 1'b1) begin errors++; $display("FAIL midrst_gnt0: got %b want 1", gnt[3]); end
    tick();
    addr[3] = BASE + 32'd4;
    #2;
    checks++; if (gnt[3] !== 1'b1) begin errors++; $display("FAIL midrst_gnt1: got %b want 1", gnt[3]); end
    tick();
    req[3] = 1'b0;
    #2;
    checks++; if (outst[3] !== 4'd2) begin errors++; $display("FAIL midrst_outstanding_pre: got %0d want 2", outst[3]); end
    rst_i = 1'b1;
    #1;
    checks++; if (outst[3] !== 4'd0) begin errors++; $display("FAIL midrst_outstanding_reset: got %0d want 0", outst[3]); end
    tick();
    rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      #2;
      if (rvalid[3] === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_stale_rvalid: got %0d pulses want 0", pulses); end
    checks++; if (outst[3] !== 4'd0) begin errors++; $display("FAIL midrst_outstanding_after: got %0d want 0", outst[3]); end
    tick();
    req[3] = 1'b1; addr[3] = BASE + 32'd12;
    #2;
    checks++; if (gnt[3] !== 1'b1) begin errors++; $display("FAIL midrst_new_gnt: got %b want 1", gnt[3]); end
    for (int c = 1; c <= 10; c++) begin
      tick();
      req[3] = 1'b0;
      #2;
      if (rvalid[3] === 1'b1 && seen < 0) begin
        seen = c;
        got  = rdata[3];
      end
    end
    checks++; if (seen !== 4) begin errors++; $display("FAIL midrst_new_latency: got cycle %0d want 4", seen); end
    checks++; if (got !== mem_word(4'd3)) begin errors++; $display("FAIL midrst_new_rdata: got %h want %h", got, mem_word(4'd3)); end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      req[k]  = 1'b0;
      addr[k] = 32'h0;
      sgnt[k] = 1'b1;
    end
    rst_i = 1'b1;
    test_reset();
    test_single_fetch();
    test_out_of_range();
    test_contention();
    test_streaming();
    test_credit_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
